breakout_framebuffer: RTL and testbench

//  Low-resolution indexed-colour framebuffer directly upstream of video_driver.

---
 rtl/breakout_framebuffer_if.sv | 28 ++
 rtl/breakout_framebuffer.sv | 147 ++++++++++++++
 tb/tb_breakout_framebuffer.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/breakout_framebuffer_if.sv
// Command and video-side signal bundle for breakout_framebuffer.
// master = game logic / video driver side, slave = framebuffer side.
interface breakout_framebuffer_if;
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_x0;
    logic [6:0] cmd_y0;
    logic [7:0] cmd_w;
    logic [6:0] cmd_h;
    logic [2:0] cmd_color;
    logic       busy;
    logic       done;

    modport master (
        output x, y, cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
        input  r, g, b, cmd_ready, busy, done
    );

    modport slave (
        input  x, y, cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
        output r, g, b, cmd_ready, busy, done
    );
endinterface

// File: rtl/breakout_framebuffer.sv
// Indexed-colour framebuffer: rectangle fill engine on the write port,
// upscaled palette lookup on the read port.
//  state  | meaning
//  S_IDLE | ready for a rectangle command
//  S_FILL | writing one pixel per clock, row-major
//  S_DONE | one-cycle completion pulse
module breakout_framebuffer #(
    parameter int FB_W  = 160,
    parameter int FB_H  = 120,
    parameter int SCALE = 4
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    breakout_framebuffer_if.slave  bus
);
    localparam int DEPTH = FB_W * FB_H;
    localparam int AW    = $clog2(DEPTH);
    localparam int SH    = $clog2(SCALE);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_x0;
    logic [6:0] r_y0;
    logic [7:0] r_w;
    logic [6:0] r_h;
    logic [2:0] r_color;
    logic [8:0] r_cx;
    logic [7:0] r_cy;
    logic [2:0] r_mem [0:DEPTH-1];
    logic [23:0] r_rgb;

    logic          w_accept;
    logic [8:0]    w_x_end;
    logic [7:0]    w_y_end;
    logic          w_last_x;
    logic          w_last;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [9:0]    w_fx;
    logic [8:0]    w_fy;
    logic          w_rd_in;
    logic [AW-1:0] w_raddr;
    logic [2:0]    w_pix;
    logic [23:0]   w_rgb;

    assign w_accept = (r_state == S_IDLE) && bus.cmd_valid;
    assign w_x_end  = {1'b0, r_x0} + {1'b0, r_w} - 9'd1;
    assign w_y_end  = {1'b0, r_y0} + {1'b0, r_h} - 8'd1;
    assign w_last_x = (r_cx == w_x_end);
    assign w_last   = w_last_x && (r_cy == w_y_end);
    // Off-screen pixels still consume their cycle; only the write is suppressed.
    assign w_we     = (r_state == S_FILL) && (r_cx < 9'(FB_W)) && (r_cy < 8'(FB_H));
    assign w_waddr  = AW'(r_cy) * AW'(FB_W) + AW'(r_cx);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid)
                    w_next = (bus.cmd_w == 8'd0 || bus.cmd_h == 7'd0) ? S_DONE : S_FILL;
            end
            S_FILL: begin
                bus.busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_x0    <= '0;
            r_y0    <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_color <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
        end else if (w_accept) begin
            r_x0    <= bus.cmd_x0;
            r_y0    <= bus.cmd_y0;
            r_w     <= bus.cmd_w;
            r_h     <= bus.cmd_h;
            r_color <= bus.cmd_color;
            r_cx    <= {1'b0, bus.cmd_x0};
            r_cy    <= {1'b0, bus.cmd_y0};
        end else if (r_state == S_FILL) begin
            if (w_last_x) begin
                r_cx <= {1'b0, r_x0};
                r_cy <= r_cy + 8'd1;
            end else begin
                r_cx <= r_cx + 9'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_we) r_mem[w_waddr] <= r_color;
    end

    assign w_fx    = bus.x >> SH;
    assign w_fy    = bus.y >> SH;
    assign w_rd_in = (w_fx < 10'(FB_W)) && (w_fy < 9'(FB_H));
    assign w_raddr = w_rd_in ? (AW'(w_fy) * AW'(FB_W) + AW'(w_fx)) : '0;
    // Combinational read ahead of the output register gives old data on a same-address write.
    assign w_pix   = r_mem[w_raddr];

    always_comb begin
        w_rgb = 24'h000000;
        case (w_pix)
            3'd0: w_rgb = 24'h000000;
            3'd1: w_rgb = 24'hFFFFFF;
            3'd2: w_rgb = 24'hFF0000;
            3'd3: w_rgb = 24'hFF8000;
            3'd4: w_rgb = 24'hFFFF00;
            3'd5: w_rgb = 24'h00FF00;
            3'd6: w_rgb = 24'h0000FF;
            3'd7: w_rgb = 24'h808080;
            default: w_rgb = 24'h000000;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)        r_rgb <= '0;
        else if (w_rd_in) r_rgb <= w_rgb;
        else              r_rgb <= '0;
    end

    assign bus.r = r_rgb[23:16];
    assign bus.g = r_rgb[15:8];
    assign bus.b = r_rgb[7:0];
endmodule

// File: tb/tb_breakout_framebuffer.sv
// Self-checking bench for breakout_framebuffer against a 2-D array model of the picture.
module tb_breakout_framebuffer;
    localparam int FB_W = 160;
    localparam int FB_H = 120;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   model [FB_H][FB_W];

    breakout_framebuffer_if bus();

    breakout_framebuffer #(.FB_W(FB_W), .FB_H(FB_H), .SCALE(4)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pal(input int c);
        case (c)
            0: return 24'h000000;
            1: return 24'hFFFFFF;
            2: return 24'hFF0000;
            3: return 24'hFF8000;
            4: return 24'hFFFF00;
            5: return 24'h00FF00;
            6: return 24'h0000FF;
            7: return 24'h808080;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] exp_px(input int sx, input int sy);
        int fx, fy;
        fx = sx / 4;
        fy = sy / 4;
        if (fx >= FB_W || fy >= FB_H) return 24'h000000;
        return pal(model[fy][fx]);
    endfunction

    // Paint the first 'limit' pixels of the rectangle in raster order.
    function automatic void model_fill(input int x0, input int y0, input int w, input int h,
                                       input int c, input int limit);
        int k;
        k = 0;
        for (int yy = y0; yy < y0 + h; yy++)
            for (int xx = x0; xx < x0 + w; xx++) begin
                if (k < limit && xx < FB_W && yy < FB_H) model[yy][xx] = c;
                k++;
            end
    endfunction

    task automatic read_px(input int sx, input int sy, output logic [23:0] rgb);
        bus.x = 10'(sx);
        bus.y = 9'(sy);
        @(posedge clk); #1;
        rgb = {bus.r, bus.g, bus.b};
    endtask

    task automatic set_fields(input int x0, input int y0, input int w, input int h, input int c);
        bus.cmd_x0    = 8'(x0);
        bus.cmd_y0    = 7'(y0);
        bus.cmd_w     = 8'(w);
        bus.cmd_h     = 7'(h);
        bus.cmd_color = 3'(c);
    endtask

    // lat = cycles after the accepting edge at which done was seen (-1 = never).
    task automatic run_cmd(input int x0, input int y0, input int w, input int h, input int c,
                           output int busy_cnt, output int done_cnt, output int lat);
        set_fields(x0, y0, w, h, c);
        bus.cmd_valid = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        lat      = -1;
        for (int i = 0; i < 50 && !bus.cmd_ready; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat >= 0) begin
            done_cnt = 1;
            @(posedge clk); #1;
            if (bus.done) done_cnt++;
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        bus.x = 10'd100;
        bus.y = 9'd100;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready);
        end
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy_done: got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        n_tests++;
        if ({bus.r, bus.g, bus.b} !== 24'h000000) begin
            n_fail++; $display("FAIL reset_rgb: got %h want 000000", {bus.r, bus.g, bus.b});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_clear();
        int bc, dc, lat;
        logic [23:0] rgb;
        int sx, sy;
        run_cmd(0, 0, FB_W, FB_H, 0, bc, dc, lat);
        for (int yy = 0; yy < FB_H; yy++)
            for (int xx = 0; xx < FB_W; xx++) model[yy][xx] = 0;
        n_tests++;
        if (bc !== FB_W * FB_H || lat !== FB_W * FB_H || dc !== 1) begin
            n_fail++; $display("FAIL clear_timing: got busy=%0d lat=%0d done=%0d want %0d %0d 1",
                               bc, lat, dc, FB_W * FB_H, FB_W * FB_H);
        end
        for (int i = 0; i < 20; i++) begin
            sx = $urandom_range(0, 639);
            sy = $urandom_range(0, 511);
            read_px(sx, sy, rgb);
            n_tests++;
            if (rgb !== exp_px(sx, sy)) begin
                n_fail++; $display("FAIL clear_read(%0d,%0d): got %h want %h", sx, sy, rgb, exp_px(sx, sy));
            end
        end
    endtask

    task automatic test_fill();
        int bc, dc, lat;
        logic [23:0] rgb;
        int sx, sy;
        run_cmd(20, 30, 10, 5, 2, bc, dc, lat);
        model_fill(20, 30, 10, 5, 2, 1 << 30);
        n_tests++;
        if (bc !== 50 || lat !== 50 || dc !== 1) begin
            n_fail++; $display("FAIL fill_timing: got busy=%0d lat=%0d done=%0d want 50 50 1", bc, lat, dc);
        end
        for (int i = 0; i < 24; i++) begin
            sx = $urandom_range(80, 119);
            sy = $urandom_range(120, 139);
            read_px(sx, sy, rgb);
            n_tests++;
            if (rgb !== 24'hFF0000) begin
                n_fail++; $display("FAIL fill_inside(%0d,%0d): got %h want ff0000", sx, sy, rgb);
            end
        end
        for (int i = 0; i < 4; i++) begin
            sx = (i % 2 == 0) ? 79 : 120;
            sy = $urandom_range(120, 139);
            read_px(sx, sy, rgb);
            n_tests++;
            if (rgb !== exp_px(sx, sy)) begin
                n_fail++; $display("FAIL fill_edge(%0d,%0d): got %h want %h", sx, sy, rgb, exp_px(sx, sy));
            end
        end
    endtask

    task automatic test_clip();
        int bc, dc, lat;
        logic [23:0] rgb;
        int sx, sy;
        run_cmd(155, 118, 10, 5, 1, bc, dc, lat);
        model_fill(155, 118, 10, 5, 1, 1 << 30);
        n_tests++;
        if (bc !== 50 || lat !== 50 || dc !== 1) begin
            n_fail++; $display("FAIL clip_timing: got busy=%0d lat=%0d done=%0d want 50 50 1", bc, lat, dc);
        end
        for (int fy = 118; fy < 120; fy++)
            for (int fx = 155; fx < 160; fx++) begin
                sx = fx * 4 + $urandom_range(0, 3);
                sy = fy * 4 + $urandom_range(0, 3);
                read_px(sx, sy, rgb);
                n_tests++;
                if (rgb !== 24'hFFFFFF) begin
                    n_fail++; $display("FAIL clip_white(%0d,%0d): got %h want ffffff", sx, sy, rgb);
                end
            end
        read_px(0, 119 * 4, rgb);
        n_tests++;
        if (rgb !== 24'h000000) begin
            n_fail++; $display("FAIL clip_col0_row119: got %h want 000000", rgb);
        end
        read_px(0, 480, rgb);
        n_tests++;
        if (rgb !== 24'h000000) begin
            n_fail++; $display("FAIL clip_row120: got %h want 000000", rgb);
        end
        read_px(640, 118 * 4, rgb);
        n_tests++;
        if (rgb !== 24'h000000) begin
            n_fail++; $display("FAIL clip_col160: got %h want 000000", rgb);
        end
        read_px(154 * 4, 118 * 4, rgb);
        n_tests++;
        if (rgb !== 24'h000000) begin
            n_fail++; $display("FAIL clip_col154: got %h want 000000", rgb);
        end
    endtask

    task automatic test_zero();
        int bc, dc, lat;
        logic [23:0] rgb;
        run_cmd(10, 10, 0, 7, 3, bc, dc, lat);
        n_tests++;
        if (bc !== 0 || lat !== 0 || dc !== 1) begin
            n_fail++; $display("FAIL zero_timing: got busy=%0d lat=%0d done=%0d want 0 0 1", bc, lat, dc);
        end
        n_tests++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL zero_ready_again: got %b want 1", bus.cmd_ready);
        end
        for (int fy = 10; fy < 17; fy++) begin
            read_px(40, fy * 4, rgb);
            n_tests++;
            if (rgb !== 24'h000000) begin
                n_fail++; $display("FAIL zero_nowrite(10,%0d): got %h want 000000", fy, rgb);
            end
        end
    endtask

    task automatic test_back_to_back();
        int a_busy, b_busy, a_ready, seen, b_seen;
        logic [23:0] rgb;
        set_fields(60, 10, 4, 3, 4);
        bus.cmd_valid = 1'b1;
        n_tests++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready_a: got %b want 1", bus.cmd_ready);
        end
        @(posedge clk); #1;
        set_fields(70, 12, 3, 2, 6);
        a_busy = 0; a_ready = 0; seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.done) begin
                seen = 1;
                break;
            end
            if (bus.busy) a_busy++;
            if (bus.cmd_ready) a_ready++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (seen !== 1 || a_busy !== 12 || a_ready !== 0) begin
            n_fail++; $display("FAIL b2b_a: got done=%0d busy=%0d ready_cycles=%0d want 1 12 0", seen, a_busy, a_ready);
        end
        n_tests++;
        if (bus.cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_ready_in_done: got %b want 0", bus.cmd_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle: got ready=%b busy=%b want 1 0", bus.cmd_ready, bus.busy);
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        b_busy = 0; b_seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.done) begin
                b_seen = 1;
                break;
            end
            if (bus.busy) b_busy++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (b_seen !== 1 || b_busy !== 6) begin
            n_fail++; $display("FAIL b2b_b: got done=%0d busy=%0d want 1 6", b_seen, b_busy);
        end
        model_fill(60, 10, 4, 3, 4, 1 << 30);
        model_fill(70, 12, 3, 2, 6, 1 << 30);
        for (int fy = 10; fy < 13; fy++)
            for (int fx = 60; fx < 64; fx++) begin
                read_px(fx * 4 + 1, fy * 4 + 2, rgb);
                n_tests++;
                if (rgb !== 24'hFFFF00) begin
                    n_fail++; $display("FAIL b2b_a_px(%0d,%0d): got %h want ffff00", fx, fy, rgb);
                end
            end
        for (int fy = 12; fy < 14; fy++)
            for (int fx = 70; fx < 73; fx++) begin
                read_px(fx * 4 + 3, fy * 4, rgb);
                n_tests++;
                if (rgb !== 24'h0000FF) begin
                    n_fail++; $display("FAIL b2b_b_px(%0d,%0d): got %h want 0000ff", fx, fy, rgb);
                end
            end
    endtask

    task automatic test_reset_mid_fill();
        logic [23:0] rgb;
        set_fields(40, 50, 10, 5, 5);
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL rmf_busy_before: got %b want 1", bus.busy);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL rmf_abort: got busy=%b ready=%b want 0 1", bus.busy, bus.cmd_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_fill(40, 50, 10, 5, 5, 20);
        for (int fy = 50; fy < 55; fy++)
            for (int fx = 40; fx < 50; fx++) begin
                read_px(fx * 4, fy * 4 + 3, rgb);
                n_tests++;
                if (rgb !== pal(model[fy][fx])) begin
                    n_fail++; $display("FAIL rmf_px(%0d,%0d): got %h want %h", fx, fy, rgb, pal(model[fy][fx]));
                end
            end
    endtask

    task automatic test_random_reads();
        logic [23:0] rgb;
        int sx, sy;
        for (int i = 0; i < 40; i++) begin
            sx = $urandom_range(0, 700);
            sy = $urandom_range(0, 511);
            if (sx > 1023) sx = 1023;
            read_px(sx, sy, rgb);
            n_tests++;
            if (rgb !== exp_px(sx, sy)) begin
                n_fail++; $display("FAIL rand_read(%0d,%0d): got %h want %h", sx, sy, rgb, exp_px(sx, sy));
            end
        end
    endtask

    initial begin
        bus.x = '0;
        bus.y = '0;
        bus.cmd_valid = 1'b0;
        set_fields(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_clear();
        test_fill();
        test_clip();
        test_zero();
        test_back_to_back();
        test_reset_mid_fill();
        test_random_reads();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
